// File: rtl/fifo_pack_pkg.sv
// rtl/fifo_pack_pkg.sv - shared defaults, FSM states and word type for the FIFO word packer
package fifo_pack_pkg;

    localparam int DEF_BYTE_W         = 8;
    localparam int DEF_BYTES_PER_WORD = 4;
    localparam int DEF_WORD_W         = DEF_BYTE_W * DEF_BYTES_PER_WORD;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_OUT   = 2'd2
    } pack_state_t;

    typedef logic [DEF_WORD_W-1:0] word_t;

endpackage

// File: rtl/pack_byte_assembler.sv
// rtl/pack_byte_assembler.sv - byte lane registers, fill count and keep mask for one output word
module pack_byte_assembler
    import fifo_pack_pkg::*;
#(
    parameter int BYTE_W         = DEF_BYTE_W,
    parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
    localparam int CNT_W         = $clog2(BYTES_PER_WORD + 1)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             capture,
    input  logic                             clear,
    input  logic [BYTE_W-1:0]                byte_in,
    output logic [CNT_W-1:0]                 cnt,
    output logic [BYTE_W*BYTES_PER_WORD-1:0] word,
    output logic [BYTES_PER_WORD-1:0]        keep
);

    logic [BYTE_W-1:0] lane_q [BYTES_PER_WORD];
    logic [BYTE_W-1:0] lane_d [BYTES_PER_WORD];
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic              accept;

    // Count saturates at a full word; a capture beyond that is dropped rather than wrapping.
    always_comb begin
        accept = capture && (cnt_q < CNT_W'(BYTES_PER_WORD));
        cnt_d  = cnt_q;
        lane_d = lane_q;
        if (clear) begin
            cnt_d = '0;
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                lane_d[i] = '0;
            end
        end else if (accept) begin
            cnt_d = cnt_q + 1'b1;
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                if (cnt_q == CNT_W'(i)) begin
                    lane_d[i] = byte_in;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                lane_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                lane_q[i] <= lane_d[i];
            end
        end
    end

    always_comb begin
        word = '0;
        keep = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            word[i*BYTE_W +: BYTE_W] = lane_q[i];
            keep[i]                  = (CNT_W'(i) < cnt_q);
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/fifo_word_packer.sv
// rtl/fifo_word_packer.sv - pops bytes from an 8-bit FIFO and packs them little-endian into words
module fifo_word_packer
    import fifo_pack_pkg::*;
#(
    parameter int BYTE_W         = DEF_BYTE_W,
    parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             fifo_empty,
    input  logic [BYTE_W-1:0]                data_outp,
    output logic                             read_en,
    input  logic                             flush,
    output logic [BYTE_W*BYTES_PER_WORD-1:0] word_data,
    output logic [BYTES_PER_WORD-1:0]        word_keep,
    output logic                             word_valid,
    input  logic                             word_ready,
    output logic                             busy
);

    localparam int             CNT_W = $clog2(BYTES_PER_WORD + 1);
    localparam logic [CNT_W:0] FULL  = (CNT_W+1)'(BYTES_PER_WORD);

    pack_state_t      state_q, state_d;
    logic             rd_pend_q, rd_pend_d;
    logic             flush_req_q, flush_req_d;
    logic             flush_word_q, flush_word_d;
    logic             flush_req_clr;
    logic             lane_clear;
    logic             handshake;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W:0]   fill_level;

    pack_byte_assembler #(
        .BYTE_W         (BYTE_W),
        .BYTES_PER_WORD (BYTES_PER_WORD)
    ) u_asm (
        .clock   (clock),
        .reset   (reset),
        .capture (rd_pend_q),
        .clear   (lane_clear),
        .byte_in (data_outp),
        .cnt     (cnt),
        .word    (word_data),
        .keep    (word_keep)
    );

    // Bytes already owned by this word, including the one arriving from the FIFO this cycle.
    assign fill_level = {1'b0, cnt} + {{CNT_W{1'b0}}, rd_pend_q};

    always_comb begin
        state_d       = state_q;
        flush_word_d  = flush_word_q;
        flush_req_clr = 1'b0;
        lane_clear    = 1'b0;
        word_valid    = (state_q == ST_OUT);
        handshake     = word_valid && word_ready;
        read_en       = reset && (state_q == ST_FILL) && !fifo_empty && !flush_req_q
                        && (fill_level < FULL);

        case (state_q)
            ST_FILL: begin
                if (fill_level == FULL) begin
                    state_d      = ST_OUT;
                    flush_word_d = 1'b0;
                end else if (flush_req_q) begin
                    if (rd_pend_q) begin
                        state_d = ST_DRAIN;
                    end else if (cnt != '0) begin
                        state_d      = ST_OUT;
                        flush_word_d = 1'b1;
                    end else begin
                        flush_req_clr = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                if (!rd_pend_q) begin
                    state_d      = ST_OUT;
                    flush_word_d = 1'b1;
                end
            end
            ST_OUT: begin
                if (handshake) begin
                    lane_clear    = 1'b1;
                    state_d       = ST_FILL;
                    flush_req_clr = flush_word_q;
                    flush_word_d  = 1'b0;
                end
            end
            default: state_d = ST_FILL;
        endcase

        // A pulse arriving while an earlier flush is being retired starts a fresh request.
        flush_req_d = (flush_req_q && !flush_req_clr) || flush;
        rd_pend_d   = read_en;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_FILL;
            rd_pend_q    <= 1'b0;
            flush_req_q  <= 1'b0;
            flush_word_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_pend_q    <= rd_pend_d;
            flush_req_q  <= flush_req_d;
            flush_word_q <= flush_word_d;
        end
    end

    assign busy = (cnt != '0) || rd_pend_q || word_valid || flush_req_q;

endmodule

// File: tb/tb_fifo_word_packer.sv
// tb/tb_fifo_word_packer.sv - randomized and directed bench for fifo_word_packer with a queue-based model
module tb_fifo_word_packer;

    localparam int BPW = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        fifo_empty;
    logic [7:0]  data_outp;
    logic        read_en;
    logic        flush;
    logic [31:0] word_data;
    logic [3:0]  word_keep;
    logic        word_valid;
    logic        word_ready;
    logic        busy;

    always #5 clock = ~clock;

    fifo_word_packer dut (
        .clock      (clock),
        .reset      (reset),
        .fifo_empty (fifo_empty),
        .data_outp  (data_outp),
        .read_en    (read_en),
        .flush      (flush),
        .word_data  (word_data),
        .word_keep  (word_keep),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .busy       (busy)
    );

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  src_q [$];
    logic [7:0]  acc [$];
    logic [35:0] exp_q [$];
    bit          force_empty = 1'b0;
    logic [31:0] last_data = '0;
    logic [3:0]  last_keep = '0;
    int          words_seen = 0;
    int          valid_cycles = 0;
    int          pops = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic upd_empty();
        fifo_empty = force_empty || (src_q.size() == 0);
    endtask

    task automatic push(input logic [7:0] b);
        src_q.push_back(b);
        upd_empty();
    endtask

    task automatic emit();
        logic [31:0] d;
        logic [3:0]  k;
        d = '0;
        k = '0;
        foreach (acc[i]) begin
            d = d | (32'(acc[i]) << (8 * i));
            k[i] = 1'b1;
        end
        exp_q.push_back({k, d});
        acc.delete();
    endtask

    task automatic tick();
        bit pop;
        bit fl;
        @(negedge clock);
        pop = read_en;
        fl  = flush;
        @(posedge clock);
        #1;
        if (pop && src_q.size() != 0) begin
            data_outp = src_q.pop_front();
            pops++;
            acc.push_back(data_outp);
            if (acc.size() == BPW) emit();
        end else begin
            data_outp = 8'($urandom);
        end
        if (fl && acc.size() != 0) emit();
        upd_empty();
    endtask

    task automatic wait_words(input int n, input string name);
        int k;
        k = 0;
        while (words_seen < n && k < 60) begin
            tick();
            k++;
        end
        check({name, "_word_timeout"}, 64'(words_seen >= n), 64'd1);
    endtask

    always @(negedge clock) begin
        if (reset) begin
            check("read_en_while_empty", 64'(read_en & fifo_empty), 64'd0);
            if (word_valid) begin
                valid_cycles++;
                check("word_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    check("word_data", 64'(word_data), 64'(exp_q[0][31:0]));
                    check("word_keep", 64'(word_keep), 64'(exp_q[0][35:32]));
                    if (word_ready) begin
                        last_data = word_data;
                        last_keep = word_keep;
                        words_seen++;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        int base;
        int k;
        int vc0;

        data_outp  = '0;
        flush      = 1'b0;
        word_ready = 1'b0;
        push(8'hEE);
        #12;
        check("rst_read_en", 64'(read_en), 64'd0);
        check("rst_word_valid", 64'(word_valid), 64'd0);
        check("rst_word_data", 64'(word_data), 64'd0);
        check("rst_word_keep", 64'(word_keep), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        src_q.delete();
        upd_empty();
        @(posedge clock);
        #1 reset = 1'b1;

        // 1: one full word, single-cycle valid, four pops
        word_ready   = 1'b1;
        pops         = 0;
        valid_cycles = 0;
        base         = words_seen;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_words(base + 1, "t1");
        repeat (3) tick();
        check("t1_data", 64'(last_data), 64'h44332211);
        check("t1_keep", 64'(last_keep), 64'hF);
        check("t1_pops", 64'(pops), 64'd4);
        check("t1_valid_cycles", 64'(valid_cycles), 64'd1);

        // 2: backpressure holds the word and stops popping
        word_ready = 1'b0;
        pops       = 0;
        base       = words_seen;
        for (int i = 0; i < 8; i++) push(8'($urandom));
        k = 0;
        while (!word_valid && k < 20) begin
            tick();
            #1;
            k++;
        end
        check("t2_valid_seen", 64'(word_valid), 64'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            check("t2_hold_valid", 64'(word_valid), 64'd1);
            check("t2_hold_read_en", 64'(read_en), 64'd0);
        end
        word_ready = 1'b1;
        wait_words(base + 2, "t2");
        check("t2_pops", 64'(pops), 64'd8);

        // 3: partial word via flush
        base = words_seen;
        push(8'hA1); push(8'hB2); push(8'hC3);
        repeat (6) tick();
        check("t3_no_early_word", 64'(words_seen), 64'(base));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        wait_words(base + 1, "t3");
        check("t3_data", 64'(last_data), 64'h00C3B2A1);
        check("t3_keep", 64'(last_keep), 64'h7);

        // 4: flush coincides with a pop, in-flight byte must be included
        base = words_seen;
        push(8'h01);
        repeat (4) tick();
        push(8'h5E);
        flush = 1'b1;
        #1;
        check("t4_read_en_with_flush", 64'(read_en), 64'd1);
        check("t4_keep_partial", 64'(word_keep), 64'h1);
        tick();
        flush = 1'b0;
        wait_words(base + 1, "t4");
        check("t4_data", 64'(last_data), 64'h00005E01);
        check("t4_keep", 64'(last_keep), 64'h3);

        // 5: flush with nothing buffered emits nothing
        repeat (3) tick();
        vc0   = valid_cycles;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        #1;
        check("t5_busy_idle", 64'(busy), 64'd0);
        repeat (4) tick();
        check("t5_no_word", 64'(valid_cycles), 64'(vc0));

        // 6: reset mid-word discards captured bytes
        push(8'h77); push(8'h88);
        repeat (5) tick();
        #1;
        check("t6_keep_before", 64'(word_keep), 64'h3);
        reset = 1'b0;
        #1;
        check("t6_read_en", 64'(read_en), 64'd0);
        check("t6_word_valid", 64'(word_valid), 64'd0);
        check("t6_word_data", 64'(word_data), 64'd0);
        check("t6_word_keep", 64'(word_keep), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        acc.delete();
        exp_q.delete();
        src_q.delete();
        upd_empty();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        base = words_seen;
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        wait_words(base + 1, "t6");
        check("t6_data", 64'(last_data), 64'h04030201);
        check("t6_keep", 64'(last_keep), 64'hF);

        // random traffic, empty toggling, backpressure and flushes
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 2) != 0 && src_q.size() < 12) src_q.push_back(8'($urandom));
            force_empty = ($urandom_range(0, 4) == 0);
            word_ready  = ($urandom_range(0, 3) != 0);
            flush       = ($urandom_range(0, 19) == 0);
            upd_empty();
            tick();
        end
        flush       = 1'b0;
        force_empty = 1'b0;
        word_ready  = 1'b1;
        upd_empty();
        k = 0;
        while (src_q.size() != 0 && k < 200) begin
            tick();
            k++;
        end
        repeat (3) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 200) begin
            tick();
            #1;
            k++;
        end
        check("end_expected_drained", 64'(exp_q.size()), 64'd0);
        check("end_model_acc_empty", 64'(acc.size()), 64'd0);
        check("end_busy", 64'(busy), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
